// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its frame timer.
package uart_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  // Half-bit ticks in one frame including the trailing idle guard bits.
  function automatic int half_bit_ticks(input int guard_bits);
    return 2 * (UART_FRAME_BITS + guard_bits);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Counts one UART frame plus guard time as half-bits of length max(period,1),
// pulsing done on the final cycle so the arbiter can leave WAIT on that edge.
module uart_frame_timer
  import uart_pkg::*;
#(
  parameter int PERIOD_W   = 32,
  parameter int GUARD_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  output logic                done
);

  localparam int TICKS  = half_bit_ticks(GUARD_BITS);
  localparam int TICK_W = $clog2(TICKS);

  logic [PERIOD_W-1:0] half_len_q, half_len_d;
  logic [PERIOD_W-1:0] half_cnt_q, half_cnt_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                running_q, running_d;
  logic                half_end;
  logic                last_tick;

  always_comb begin
    half_end   = (half_cnt_q == half_len_q - PERIOD_W'(1));
    last_tick  = (tick_q == TICK_W'(TICKS - 1));
    done       = running_q & half_end & last_tick;
    half_len_d = half_len_q;
    half_cnt_d = half_cnt_q;
    tick_d     = tick_q;
    running_d  = running_q;
    if (load) begin
      // period is latched here so later changes only affect the next frame
      half_len_d = (period == '0) ? PERIOD_W'(1) : period;
      half_cnt_d = '0;
      tick_d     = '0;
      running_d  = 1'b1;
    end else if (running_q) begin
      if (half_end) begin
        half_cnt_d = '0;
        tick_d     = last_tick ? '0 : tick_q + 1'b1;
        running_d  = ~last_tick;
      end else begin
        half_cnt_d = half_cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_len_q <= PERIOD_W'(1);
      half_cnt_q <= '0;
      tick_q     <= '0;
      running_q  <= 1'b0;
    end else begin
      half_len_q <= half_len_d;
      half_cnt_q <= half_cnt_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ byte producers, each with a
// one-byte holding slot; one slot is issued per frame as a single in_sync pulse.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PERIOD_W   = 32,
  parameter int GUARD_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PERIOD_W-1:0]      period,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_sync,
  output logic [7:0]               tx_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_e      state_q, state_d;
  logic [N_REQ-1:0] full_q, full_d;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] clear;
  logic [7:0]      slot_data_q [N_REQ];
  logic [7:0]      slot_data_d [N_REQ];
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_sync_q, tx_sync_d;
  logic            busy_q, busy_d;
  logic [ID_W-1:0] pick;
  logic            pick_valid;
  logic            timer_done;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign accept[gi]      = req_valid[gi] & ~full_q[gi];
    assign clear[gi]       = (state_q == ISSUE) && (grant_id_q == ID_W'(gi));
    assign full_d[gi]      = accept[gi] | (full_q[gi] & ~clear[gi]);
    assign slot_data_d[gi] = accept[gi] ? req_data[8*gi +: 8] : slot_data_q[gi];
  end

  // Scan downward in offset so the slot closest to ptr is the one that sticks.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = ptr_q;
    pick_valid = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (full_q[idx]) begin
        pick       = ID_W'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_sync_d  = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = ISSUE;
          grant_id_d = pick;
          tx_data_d  = slot_data_q[pick];
          tx_sync_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        ptr_d   = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
      end
      WAIT: begin
        if (timer_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      full_q     <= '0;
      ptr_q      <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_sync_q  <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < N_REQ; i++) slot_data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_sync_q  <= tx_sync_d;
      busy_q     <= busy_d;
      for (int i = 0; i < N_REQ; i++) slot_data_q[i] <= slot_data_d[i];
    end
  end

  uart_frame_timer #(
    .PERIOD_W  (PERIOD_W),
    .GUARD_BITS(GUARD_BITS)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (state_q == ISSUE),
    .period(period),
    .done  (timer_done)
  );

  assign req_ready = ~full_q;
  assign tx_sync   = tx_sync_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule
